// File: rtl/sw_debounce.sv
// Per-bit switch debouncer: 2-flop synchronizer, saturating stability counter,
// registered level plus one-cycle rise/fall/change pulses.
module sw_debounce #(
   parameter int unsigned WIDTH   = 2,
   parameter int unsigned CNT_MAX = 1000000
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_i,
   output logic [WIDTH-1:0] sw_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             chg_o
);

   localparam int unsigned     CW       = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

   logic [WIDTH-1:0]          sync1_q, sync2_q;
   logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]          sw_q, sw_d;
   logic [WIDTH-1:0]          rise_q, rise_d;
   logic [WIDTH-1:0]          fall_q, fall_d;
   logic                      chg_q, chg_d;

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      sw_d   = sw_q;
      rise_d = '0;
      fall_d = '0;
      cnt_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync2_q[i] != sw_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               sw_d[i]   = sync2_q[i];
               rise_d[i] = sync2_q[i];
               fall_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      // Derived from the next-state pulses so chg_o lands on the same edge as sw_o.
      chg_d = |(rise_d | fall_d);
   end

   // NOTE: sequential state uses non-blocking assignments only; the counters are
   // reset along with everything else since a stale count would shorten the next accept.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cnt_q   <= '0;
         sw_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         chg_q   <= 1'b0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         sw_q    <= sw_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         chg_q   <= chg_d;
      end
   end

   assign sw_o   = sw_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign chg_o  = chg_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (WIDTH=2, CNT_MAX=4): the driver queues the
// expected outputs for each edge, the monitor pops and compares after that edge.
module tb_sw_debounce;

   localparam int unsigned WIDTH   = 2;
   localparam int unsigned CNT_MAX = 4;

   typedef struct {
      string            tag;
      logic [WIDTH-1:0] sw;
      logic [WIDTH-1:0] rise;
      logic [WIDTH-1:0] fall;
      logic             chg;
   } exp_t;

   logic             clk_i = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] sw_i;
   logic [WIDTH-1:0] sw_o, rise_o, fall_o;
   logic             chg_o;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_passed = 0;
   int   edge_cnt = 0;

   sw_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) dut (
      .clk_i  (clk_i),
      .rst_n  (rst_n),
      .sw_i   (sw_i),
      .sw_o   (sw_o),
      .rise_o (rise_o),
      .fall_o (fall_o),
      .chg_o  (chg_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      n_checks++;
      if (actual === expected) n_passed++;
      else $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, edge_cnt, actual, expected);
   endtask

   // Monitor: compares after every edge for which the driver queued an expectation.
   always @(posedge clk_i) begin
      edge_cnt++;
      #1;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.tag, ".sw_o"},   8'(sw_o),   8'(e.sw));
         check({e.tag, ".rise_o"}, 8'(rise_o), 8'(e.rise));
         check({e.tag, ".fall_o"}, 8'(fall_o), 8'(e.fall));
         check({e.tag, ".chg_o"},  8'(chg_o),  8'(e.chg));
      end
   end

   // One edge of stimulus plus the outputs expected right after that edge.
   task automatic drive(input string tag, input logic rst, input logic [WIDTH-1:0] sw,
                        input logic [WIDTH-1:0] e_sw, input logic [WIDTH-1:0] e_rise,
                        input logic [WIDTH-1:0] e_fall);
      exp_t e;
      @(negedge clk_i);
      rst_n = rst;
      sw_i  = sw;
      e.tag  = tag;
      e.sw   = e_sw;
      e.rise = e_rise;
      e.fall = e_fall;
      e.chg  = |(e_rise | e_fall);
      sb_q.push_back(e);
   endtask

   task automatic hold(input string tag, input logic [WIDTH-1:0] sw, input int n,
                       input logic [WIDTH-1:0] e_sw);
      for (int k = 0; k < n; k++) drive(tag, 1'b1, sw, e_sw, '0, '0);
   endtask

   // A change applied before edge 1 is accepted on edge CNT_MAX+2.
   task automatic accept(input string tag, input logic [WIDTH-1:0] from_sw,
                         input logic [WIDTH-1:0] to_sw);
      hold(tag, to_sw, CNT_MAX + 1, from_sw);
      drive(tag, 1'b1, to_sw, to_sw, to_sw & ~from_sw, from_sw & ~to_sw);
      hold(tag, to_sw, 4, to_sw);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      sw_i  = '0;
      @(negedge clk_i);

      // Reset clears everything regardless of sw_i.
      drive("reset", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
      drive("reset", 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
      drive("reset", 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
      drive("reset", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
      hold("idle_after_reset", 2'b00, 8, 2'b00);

      accept("clean_press", 2'b00, 2'b01);
      accept("release", 2'b01, 2'b00);

      // Bounce: 1,0,1,0 for 2 edges each, then a steady 1.
      hold("bounce", 2'b01, 2, 2'b00);
      hold("bounce", 2'b00, 2, 2'b00);
      hold("bounce", 2'b01, 2, 2'b00);
      hold("bounce", 2'b00, 2, 2'b00);
      accept("bounce_settle", 2'b00, 2'b01);
      accept("bounce_release", 2'b01, 2'b00);

      accept("simul_press", 2'b00, 2'b11);
      accept("simul_part_release", 2'b11, 2'b10);
      accept("simul_release", 2'b10, 2'b00);

      // Reset asserted on edge 4 of a count; the held input is re-accepted afterwards.
      hold("rst_mid", 2'b01, 3, 2'b00);
      drive("rst_mid", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
      accept("rst_mid_reaccept", 2'b00, 2'b01);
      accept("rst_mid_release", 2'b01, 2'b00);

      // Glitch one edge shorter than the count window: never accepted.
      hold("glitch", 2'b10, CNT_MAX - 1, 2'b00);
      hold("glitch", 2'b00, 10, 2'b00);

      // Longer idle stretch: output stays put.
      hold("stable", 2'b00, 20, 2'b00);

      for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk_i);
      #2;
      check("scoreboard_drain", 8'(sb_q.size()), 8'd0);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of switch inputs debounced.
REQ-002 SHALL have parameter CNT_MAX, default 1000000: stable-sample count needed to accept a change (20 ms at 50 MHz); legal range 1..2^24-1.
REQ-003 SHALL have port clk_i, input, 1: single clock domain for all state.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port sw_i, input, WIDTH: raw asynchronous switch levels from board pins.
REQ-006 SHALL have port sw_o, output, WIDTH: debounced switch levels (feeds the pattern-select decoder).
REQ-007 SHALL have port rise_o, output, WIDTH: per-bit one-cycle pulse when sw_o[i] goes 0->1.
REQ-008 SHALL have port fall_o, output, WIDTH: per-bit one-cycle pulse when sw_o[i] goes 1->0.
REQ-009 SHALL have port chg_o, output, 1: one-cycle pulse when any sw_o bit changes (OR of rise_o|fall_o, registered).

Function
REQ-010 SHALL pass sw_i through a 2-flop synchronizer (sync1, sync2) per bit; no combinational path from sw_i to any output.
REQ-011 SHALL keep one independent counter per bit, width ceil(log2(CNT_MAX+1)), never wrapping.
REQ-012 SHALL, per bit each edge: if sync2[i]==sw_o[i], clear cnt[i] to 0.
REQ-013 SHALL, per bit each edge: if sync2[i]!=sw_o[i] and cnt[i]<CNT_MAX-1, increment cnt[i].
REQ-014 SHALL, per bit each edge: if sync2[i]!=sw_o[i] and cnt[i]==CNT_MAX-1, load sw_o[i]<=sync2[i], clear cnt[i], assert rise_o[i] or fall_o[i] for exactly that next cycle.
REQ-015 SHALL register all outputs; rise_o, fall_o, chg_o high for exactly one cycle per accepted change, coincident with the sw_o update.
REQ-016 SHALL yield latency of exactly CNT_MAX+2 clk_i edges from a clean sw_i change (set up before edge 1) to sw_o update (edge CNT_MAX+2).
REQ-017 SHALL discard any bounce: if sync2[i] returns to sw_o[i] before the count completes, cnt[i] clears and no output changes.
REQ-018 SHALL handle bits independently; simultaneous changes on several bits each produce their own rise/fall pulse, single chg_o pulse.
REQ-019 SHALL, with CNT_MAX=1, accept a change after exactly 3 edges (synchronizer + one compare).
REQ-020 SHALL hold sw_o stable indefinitely while sync2 equals sw_o; counters stay 0.

Reset
REQ-021 SHALL, on any clk_i edge with rst_n==0, set sync1, sync2, cnt, sw_o, rise_o, fall_o, chg_o to 0 regardless of sw_i.
REQ-022 SHALL, if rst_n asserts mid-count, discard the count; after release a held-high sw_i[i] is re-accepted CNT_MAX+2 edges later with rise_o[i] and chg_o pulsing.
REQ-023 SHALL, when rst_n is released with sw_i all 0, produce no pulses.

Verification (CNT_MAX=4, WIDTH=2)
REQ-024 SHALL cover clean press: reset, sw_i 00->01 before edge 1 -> sw_o=01 at edge 6, rise_o=01 and chg_o=1 for one cycle, fall_o=00.
REQ-025 SHALL cover bounce: sw_i[0] toggles 1,0,1,0 every 2 cycles then holds 1 -> no change until 6 edges after final rise; exactly one rise_o[0] pulse.
REQ-026 SHALL cover release: from sw_o=01, sw_i->00 -> sw_o=00 at edge 6, fall_o=01 one cycle, rise_o=00.
REQ-027 SHALL cover simultaneous: sw_i 00->11 -> sw_o=11 at edge 6, rise_o=11, single chg_o pulse; then sw_i 11->10 -> only fall_o=01.
REQ-028 SHALL cover reset mid-count: sw_i=01, rst_n low at edge 4 for one cycle -> sw_o stays 00, then 01 at 6 edges after release with rise_o[0] pulse.
REQ-029 SHALL cover glitch shorter than CNT_MAX: 3-cycle sw_i[1] pulse -> sw_o, rise_o, fall_o, chg_o remain 0 throughout.
